// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - job request, shifter handshake and completion signals of shift_sequencer
interface shift_sequencer_if #(
  parameter int n = 4,
  parameter int m = 3
) ();
  logic         start;
  logic [n-1:0] operand;
  logic [m-1:0] amount;
  logic         shift_en;
  logic [n-1:0] shift_in;
  logic [n-1:0] shift_out;
  logic         busy;
  logic         done;
  logic [n-1:0] result;

  // Requester side: issues jobs, hosts the single-step shifter, consumes status.
  modport master (
    output start, operand, amount, shift_out,
    input  shift_en, shift_in, busy, done, result
  );

  // Sequencer side.
  modport slave (
    input  start, operand, amount, shift_out,
    output shift_en, shift_in, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-step left shift sequencer driving an external one-bit shifter (option: SHIFT_SEQ_FASTZERO_EN)
module shift_sequencer #(
  parameter int n = 4,
  parameter int m = 3
) (
  input logic              clock,
  input logic              reset_n,
  shift_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   r_state;
  logic [1:0]   w_next;
  logic [n-1:0] r_work;
  logic [n-1:0] r_result;
  logic [m-1:0] r_count;
  logic         w_accept;
  logic         w_fast;

  assign w_accept = (r_state == IDLE) && bus.start;

`ifdef SHIFT_SEQ_FASTZERO_EN
  // An amount of n or more shifts everything out, so the answer is known at accept time.
  localparam logic [31:0] N32 = n;
  assign w_fast = ({{(32-m){1'b0}}, bus.amount} >= N32);
`else
  assign w_fast = 1'b0;
`endif

  // Next-state decode; start is only looked at in IDLE, so requests while busy are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = (w_fast || bus.amount == '0) ? DONE : SHIFT;
      SHIFT:   w_next = WAIT;
      WAIT:    w_next = (r_count == m'(1)) ? DONE : SHIFT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; asynchronous reset abandons any job in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Work/counter/result datapath: load on accept, take shifter output in WAIT, publish in DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_work   <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_work  <= w_fast ? '0 : bus.operand;
        r_count <= bus.amount;
      end
      if (r_state == WAIT) begin
        r_work  <= bus.shift_out;
        r_count <= r_count - m'(1);
      end
      if (r_state == DONE) r_result <= r_work;
    end
  end

  assign bus.shift_en = (r_state == SHIFT);
  assign bus.shift_in = r_work;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.result   = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer with a one-bit shifter model
module tb_shift_sequencer;
  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  shift_sequencer_if #(.n(4), .m(3)) bus ();

  shift_sequencer #(.n(4), .m(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream shifter: result valid the cycle after shift_en is sampled.
  initial bus.shift_out = '0;
  always @(posedge clock) if (bus.shift_en) bus.shift_out <= bus.shift_in << 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One job: accepted on the posedge after the first negedge; cycle 1 is the cycle after accept.
  task automatic run_job(input string tag, input logic [3:0] op, input logic [2:0] amt,
                         input logic [3:0] exp_res, input logic [3:0] prev_res,
                         input int exp_lat, input int exp_pulses, input bit poke_busy);
    int cyc;
    int pulses;
    int lat;
    cyc = 1; pulses = 0; lat = -1;
    @(negedge clock);
    bus.start = 1'b1; bus.operand = op; bus.amount = amt;
    @(negedge clock);
    bus.start = 1'b0;
    bus.operand = 4'b0110; bus.amount = 3'd7;
    while (cyc <= 40) begin
      if (bus.shift_en) pulses++;
      if (bus.done) begin
        lat = cyc;
        chk({tag, "_hold"}, 32'(bus.result), 32'(prev_res));
        break;
      end
      bus.start = poke_busy && (cyc == 2);
      @(negedge clock);
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    @(negedge clock);
    chk({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int dones;
    total = 0; bad = 0;
    bus.start = 1'b0; bus.operand = '0; bus.amount = '0;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_shift_en", {31'd0, bus.shift_en}, 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_shift_in", 32'(bus.shift_in), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run_job("a1", 4'b1010, 3'd1, 4'b0100, 4'b0000, 3, 1, 1'b0);
    run_job("a2", 4'b0011, 3'd2, 4'b1100, 4'b0100, 5, 2, 1'b1);
    run_job("a0", 4'b1011, 3'd0, 4'b1011, 4'b1100, 1, 0, 1'b0);
`ifdef SHIFT_SEQ_FASTZERO_EN
    run_job("a5", 4'b1010, 3'd5, 4'b0000, 4'b1011, 1, 0, 1'b0);
    run_job("a4", 4'b1111, 3'd4, 4'b0000, 4'b0000, 1, 0, 1'b0);
`else
    run_job("a5", 4'b1010, 3'd5, 4'b0000, 4'b1011, 11, 5, 1'b0);
    run_job("a4", 4'b1111, 3'd4, 4'b0000, 4'b0000, 9, 4, 1'b0);
`endif
    run_job("a3", 4'b0101, 3'd3, 4'b1000, 4'b0000, 7, 3, 1'b0);

    // Reset in the cycle after the first shift_en pulse.
    @(negedge clock);
    bus.start = 1'b1; bus.operand = 4'b0001; bus.amount = 3'd3;
    @(negedge clock);
    bus.start = 1'b0;
    chk("mid_shift_en", {31'd0, bus.shift_en}, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_result", 32'(bus.result), 32'd0);
    chk("mid_shift_en_off", {31'd0, bus.shift_en}, 32'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    chk("mid_no_done", 32'(dones), 32'd0);
    run_job("post_rst", 4'b0001, 3'd3, 4'b1000, 4'b0000, 7, 3, 1'b0);

    // start held high relaunches on each return to IDLE.
    @(negedge clock);
    bus.start = 1'b1; bus.operand = 4'b0011; bus.amount = 3'd1;
    cyc = 0;
    @(negedge clock);
    cyc = 1;
    while (cyc < 4) begin @(negedge clock); cyc++; end
    chk("hold_idle_c4", {31'd0, bus.busy}, 32'd0);
    chk("hold_result1", 32'(bus.result), 32'b0110);
    @(negedge clock);
    chk("hold_relaunch", {31'd0, bus.shift_en}, 32'd1);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20) begin @(negedge clock); cyc++; end
    chk("hold_done2", {31'd0, bus.done}, 32'd1);
    @(negedge clock);
    chk("hold_result2", 32'(bus.result), 32'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter n, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter m, default 3, giving the shift-amount width in bits.
REQ-003 Port clock, input, 1, the single clock for the block; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, request to begin a shift job; sampled only in IDLE.
REQ-006 Port operand, input, n, value to be shifted; latched when start is accepted.
REQ-007 Port amount, input, m, number of single-bit left shifts; latched when start is accepted.
REQ-008 Port shift_en, output, 1, enable to the downstream single-step left shifter.
REQ-009 Port shift_in, output, n, operand presented to the shifter.
REQ-010 Port shift_out, input, n, shifter result.
REQ-011 Port busy, output, 1, high in every state except IDLE.
REQ-012 Port done, output, 1, one-cycle completion pulse.
REQ-013 Port result, output, n, final shifted value.

Function
REQ-014 Shifter contract: shift_out SHALL equal shift_in shifted left by 1 with zero fill, valid the cycle after shift_en is sampled high.
REQ-015 States: IDLE, SHIFT, WAIT, DONE.
REQ-016 IDLE: when start=1, the block SHALL latch operand into work register and amount into counter; next state SHIFT if amount!=0, else DONE.
REQ-017 SHIFT: shift_en=1 and shift_in=work for exactly one cycle; next state WAIT.
REQ-018 WAIT: shift_en=0; at cycle end work<=shift_out and counter decrements; next state DONE if counter was 1, else SHIFT.
REQ-019 DONE: done=1 and result<=work for one cycle; next state IDLE.
REQ-020 Latency from the start-accept edge to done high SHALL be 2*amount+1 cycles; shift_en SHALL pulse exactly amount times.
REQ-021 shift_in SHALL present work in all states; shift_en SHALL be 0 outside SHIFT.
REQ-022 result SHALL hold its value until the next DONE, independent of start, operand and amount.
REQ-023 start asserted while busy=1 SHALL be ignored, not queued.
REQ-024 start held high continuously SHALL launch a new job on each return to IDLE.
REQ-025 amount values >= n SHALL yield result zero.

Reset
REQ-026 reset_n low SHALL immediately force state IDLE and clear work, counter and result to zero, with shift_en=0, busy=0, done=0.
REQ-027 Reset asserted mid-job SHALL abandon the job without a done pulse; the first start after reset_n rises SHALL be accepted normally.

Configuration
REQ-028 Macro SHIFT_SEQ_FASTZERO_EN: when defined, a start with amount >= n SHALL go directly IDLE->DONE with result zero, done one cycle after accept, and no shift_en pulses.
REQ-029 Without SHIFT_SEQ_FASTZERO_EN, amount >= n SHALL run the full 2*amount+1 cycle sequence per REQ-016..REQ-020.

Verification (n=4, m=3)
REQ-030 operand=1010, amount=1, start pulse -> one shift_en pulse, done 3 cycles after accept, result=0100.
REQ-031 operand=0011, amount=2 -> two shift_en pulses, done after 5 cycles, result=1100; start=1 in cycle 2 ignored, result unchanged.
REQ-032 operand=1011, amount=0 -> no shift_en, done after 1 cycle, result=1011.
REQ-033 operand=1010, amount=5 -> with SHIFT_SEQ_FASTZERO_EN: done after 1 cycle, no shift_en, result=0000; without: 5 shift_en pulses, done after 11 cycles, result=0000.
REQ-034 operand=0001, amount=3, reset_n low in the cycle after the first shift_en -> immediate busy=0, result=0000, no done; new job operand=0001, amount=3 -> result=1000 after 7 cycles.
